// File: rtl/wdt_prescaler.sv
// APB-programmable pclk divider producing the window watchdog decrement strobe (wdt_tick).
// Define WDT_PSC_DBG_FREEZE_EN to add the dbg_halt input that freezes the count while debugging.
module wdt_prescaler #(
    parameter int DIV_W  = 16,
    parameter int TCNT_W = 8
) (
    input  logic        pclk,
    input  logic        prstn,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] paddr,
    input  logic [31:0] pwdata,
`ifdef WDT_PSC_DBG_FREEZE_EN
    input  logic        dbg_halt,
`endif
    output logic [31:0] prdata,
    output logic        pready,
    output logic        wdt_tick
);

    localparam logic [3:0] ADDR_CTRL   = 4'h0;
    localparam logic [3:0] ADDR_RELOAD = 4'h1;
    localparam logic [3:0] ADDR_COUNT  = 4'h2;
    localparam logic [3:0] ADDR_STATUS = 4'h3;

    logic              r_en;
    logic [DIV_W-1:0]  r_reload;
    logic [DIV_W-1:0]  r_cnt;
    logic [TCNT_W-1:0] r_tickCnt;
    logic              r_tick;

    logic              w_wr;
    logic              w_ctrlWr;
    logic              w_reloadWr;
    logic              w_statusWr;
    logic              w_halt;
    logic              w_unused;

    assign w_wr       = psel & penable & pwrite;
    assign w_ctrlWr   = w_wr & (paddr[3:0] == ADDR_CTRL);
    assign w_reloadWr = w_wr & (paddr[3:0] == ADDR_RELOAD);
    assign w_statusWr = w_wr & (paddr[3:0] == ADDR_STATUS);

`ifdef WDT_PSC_DBG_FREEZE_EN
    assign w_halt = dbg_halt;
`else
    assign w_halt = 1'b0;
`endif

    assign w_unused = ^{paddr[31:4], pwdata[31:DIV_W]};

    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_en     <= 1'b0;
            r_reload <= '0;
        end else begin
            if (w_ctrlWr) begin
                r_en <= pwdata[0];
            end
            if (w_reloadWr) begin
                r_reload <= pwdata[DIV_W-1:0];
            end
        end
    end

    // Counter acts on the EN value held before this edge, so an EN 0->1 write lands in
    // the reload branch, and a RELOAD write only takes effect at the next reload.
    always_ff @(posedge pclk or negedge prstn) begin
        if (!prstn) begin
            r_cnt     <= '0;
            r_tick    <= 1'b0;
            r_tickCnt <= '0;
        end else begin
            if (!r_en) begin
                r_cnt  <= r_reload;
                r_tick <= 1'b0;
            end else if (w_halt) begin
                r_tick <= 1'b0;
            end else if (r_cnt == '0) begin
                r_cnt     <= r_reload;
                r_tick    <= 1'b1;
                r_tickCnt <= r_tickCnt + 1'b1;
            end else begin
                r_cnt  <= r_cnt - 1'b1;
                r_tick <= 1'b0;
            end
            // A software clear overrides a coincident increment.
            if (w_statusWr) begin
                r_tickCnt <= '0;
            end
        end
    end

    always_comb begin
        prdata = '0;
        if (psel && !pwrite) begin
            case (paddr[3:0])
                ADDR_CTRL:   prdata[0]          = r_en;
                ADDR_RELOAD: prdata[DIV_W-1:0]  = r_reload;
                ADDR_COUNT:  prdata[DIV_W-1:0]  = r_cnt;
                ADDR_STATUS: prdata[TCNT_W-1:0] = r_tickCnt;
                default:     prdata             = '0;
            endcase
        end
    end

    assign pready   = 1'b1;
    assign wdt_tick = r_tick;

endmodule
